// File: rtl/psum_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : psum_accum                                                   |
// | Description : Accumulates conv-array psum beats over a group, then applies |
// |               per-channel bias, ReLU, right-shift and uint8 saturation.    |
// |               Define ACC_SAT_EN for saturating accumulate/bias-add.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module psum_accum #(
    parameter int CH     = 32,
    parameter int NPIX   = 4,
    parameter int PSUM_W = 32,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psum_valid,
    output logic                      psum_ready,
    input  logic                      psum_last,
    input  logic [CH*NPIX*PSUM_W-1:0] psum,
    input  logic [CH*PSUM_W-1:0]      bias,
    input  logic [4:0]                shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH*NPIX*OUT_W-1:0]  out_data,
    output logic [CNT_W-1:0]          beat_cnt
);

    localparam int         c_NEL     = CH * NPIX;
    localparam logic [1:0] c_ST_ACC  = 2'd0;
    localparam logic [1:0] c_ST_POST = 2'd1;
    localparam logic [1:0] c_ST_OUT  = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic                     r_first;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_out_valid;
    logic [c_NEL*OUT_W-1:0]   r_out_data;
    logic [CNT_W-1:0]         r_beat_cnt;
    logic [PSUM_W-1:0]        r_acc     [c_NEL];
    logic [PSUM_W-1:0]        w_acc_nxt [c_NEL];
    logic [c_NEL*OUT_W-1:0]   w_act;
    logic                     w_accept;

    // Two's-complement add; clamps on signed overflow when saturation is built in.
    function automatic logic [PSUM_W-1:0] f_add(input logic [PSUM_W-1:0] a,
                                                input logic [PSUM_W-1:0] b);
        logic [PSUM_W-1:0] w_sum;
        w_sum = a + b;
`ifdef ACC_SAT_EN
        if ((a[PSUM_W-1] == b[PSUM_W-1]) && (w_sum[PSUM_W-1] != a[PSUM_W-1]))
            w_sum = a[PSUM_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
`endif
        return w_sum;
    endfunction

    function automatic logic [OUT_W-1:0] f_act(input logic [PSUM_W-1:0] s,
                                               input logic [4:0]        sh);
        logic [PSUM_W-1:0] w_shr;
        logic [OUT_W-1:0]  w_res;
        w_shr = s >> sh;
        if (s[PSUM_W-1])
            w_res = '0;
        else if (|w_shr[PSUM_W-1:OUT_W])
            w_res = '1;
        else
            w_res = w_shr[OUT_W-1:0];
        return w_res;
    endfunction

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        for (genvar gk = 0; gk < NPIX; gk++) begin : g_px
            localparam int c_E = gi * NPIX + gk;
            assign w_acc_nxt[c_E] = r_first ? psum[c_E*PSUM_W +: PSUM_W]
                                            : f_add(r_acc[c_E], psum[c_E*PSUM_W +: PSUM_W]);
            assign w_act[c_E*OUT_W +: OUT_W] =
                f_act(f_add(r_acc[c_E], bias[gi*PSUM_W +: PSUM_W]), shift);
        end
    end

    assign w_accept = psum_valid & psum_ready;

    always_comb begin
        w_state_nxt = r_state;
        psum_ready  = 1'b0;
        case (r_state)
            c_ST_ACC: begin
                psum_ready = 1'b1;
                if (psum_valid && psum_last)
                    w_state_nxt = c_ST_POST;
            end
            c_ST_POST: w_state_nxt = c_ST_OUT;
            c_ST_OUT: begin
                if (out_ready)
                    w_state_nxt = c_ST_ACC;
            end
            default: w_state_nxt = c_ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_ACC;
            r_first     <= 1'b1;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_beat_cnt  <= '0;
            for (int i = 0; i < c_NEL; i++)
                r_acc[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                for (int i = 0; i < c_NEL; i++)
                    r_acc[i] <= w_acc_nxt[i];
                // The last beat re-arms the load so the next group overwrites.
                r_first <= psum_last;
                if (r_cnt != '1)
                    r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == c_ST_POST) begin
                r_out_data  <= w_act;
                r_out_valid <= 1'b1;
                r_beat_cnt  <= r_cnt;
                r_cnt       <= '0;
            end
            if ((r_state == c_ST_OUT) && out_ready)
                r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_psum_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_psum_accum                                                |
// | Description : Directed scoreboard bench for psum_accum (honours ACC_SAT_EN)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_psum_accum;

    localparam int c_CH   = 32;
    localparam int c_NPIX = 4;
    localparam int c_NEL  = c_CH * c_NPIX;
    localparam int c_PW   = 32;
    localparam int c_OW   = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    psum_valid;
    logic                    psum_ready;
    logic                    psum_last;
    logic [c_NEL*c_PW-1:0]   psum;
    logic [c_CH*c_PW-1:0]    bias;
    logic [4:0]              shift;
    logic                    out_valid;
    logic                    out_ready;
    logic [c_NEL*c_OW-1:0]   out_data;
    logic [7:0]              beat_cnt;

    typedef struct {
        logic [c_NEL*c_OW-1:0] data;
        logic [7:0]            cnt;
    } exp_t;

    exp_t   r_sbq[$];
    longint r_macc [c_NEL];
    bit     r_mfirst;
    int     r_mcnt;
    int     n_total = 0;
    int     n_pass  = 0;

    psum_accum dut (
        .clk        (clk),
        .rst        (rst),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_last  (psum_last),
        .psum       (psum),
        .bias       (bias),
        .shift      (shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_data(input string tag, input logic [c_NEL*c_OW-1:0] obs,
                            input logic [c_NEL*c_OW-1:0] exp);
        int bad;
        bad = 0;
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            for (int e = c_NEL - 1; e >= 0; e--)
                if (obs[e*c_OW +: c_OW] !== exp[e*c_OW +: c_OW]) bad = e;
            $error("FAIL %s: element %0d observed %0d expected %0d", tag, bad,
                   obs[bad*c_OW +: c_OW], exp[bad*c_OW +: c_OW]);
        end
    endtask

    function automatic longint norm(input longint x);
        logic [31:0] lo;
`ifdef ACC_SAT_EN
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
`else
        lo = x[31:0];
        return longint'($signed(lo));
`endif
    endfunction

    function automatic logic [c_NEL*c_PW-1:0] fill(input int val);
        logic [c_NEL*c_PW-1:0] v;
        for (int e = 0; e < c_NEL; e++) v[e*c_PW +: c_PW] = 32'(val);
        return v;
    endfunction

    function automatic logic [c_CH*c_PW-1:0] fill_bias(input int val);
        logic [c_CH*c_PW-1:0] v;
        for (int c = 0; c < c_CH; c++) v[c*c_PW +: c_PW] = 32'(val);
        return v;
    endfunction

    task automatic model_reset();
        r_mfirst = 1'b1;
        r_mcnt   = 0;
    endtask

    // Drives one beat, updates the model, and on the last beat pushes the expected group.
    task automatic drive_beat(input logic [c_NEL*c_PW-1:0] v, input bit last);
        int     waited;
        longint s;
        longint t;
        exp_t   ex;
        logic [31:0] pv;
        logic [31:0] bv;
        psum_valid = 1'b1;
        psum       = v;
        psum_last  = last;
        waited     = 0;
        while (!psum_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!psum_ready) chk("beat_accept_timeout", 64'(psum_ready), 64'd1);
        step();
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        for (int e = 0; e < c_NEL; e++) begin
            pv = v[e*c_PW +: c_PW];
            r_macc[e] = r_mfirst ? longint'($signed(pv)) : norm(r_macc[e] + longint'($signed(pv)));
        end
        r_mfirst = 1'b0;
        if (r_mcnt < 255) r_mcnt++;
        if (last) begin
            for (int e = 0; e < c_NEL; e++) begin
                bv = bias[(e / c_NPIX)*c_PW +: c_PW];
                s  = norm(r_macc[e] + longint'($signed(bv)));
                if (s < 0) t = 0;
                else t = s >>> shift;
                if (t > 255) t = 255;
                ex.data[e*c_OW +: c_OW] = 8'(t);
            end
            ex.cnt = 8'(r_mcnt);
            r_sbq.push_back(ex);
            model_reset();
        end
    endtask

    task automatic recv(input string tag);
        int   waited;
        exp_t ex;
        waited = 0;
        while (!out_valid && waited < 20) begin
            step();
            waited++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (r_sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(r_sbq.size()), 64'd1);
        end else begin
            ex = r_sbq.pop_front();
            chk_data({tag, "_data"}, out_data, ex.data);
            chk({tag, "_cnt"}, 64'(beat_cnt), 64'(ex.cnt));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk({tag, "_drop"}, 64'(out_valid), 64'd0);
            chk_data({tag, "_held"}, out_data, ex.data);
        end
    endtask

    initial begin
        logic [c_NEL*c_PW-1:0] v;
        logic [c_NEL*c_OW-1:0] hold;
        exp_t                  ex;
        int                    val;

        rst = 1'b1; psum_valid = 1'b0; psum_last = 1'b0; psum = '0;
        bias = '0; shift = '0; out_ready = 1'b0;
        model_reset();
        step(); step();
        rst = 1'b0;
        chk("rst_psum_ready", 64'(psum_ready), 64'd1);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_data",   64'(out_data[63:0]), 64'd0);
        chk("rst_beat_cnt",   64'(beat_cnt),   64'd0);

        // Reset in the middle of a group discards the partial accumulation.
        drive_beat(fill(1000), 1'b0);
        drive_beat(fill(1000), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("midrst_psum_ready", 64'(psum_ready), 64'd1);
        chk("midrst_out_valid",  64'(out_valid),  64'd0);
        chk("midrst_beat_cnt",   64'(beat_cnt),   64'd0);
        drive_beat(fill(7), 1'b1);
        chk_data("midrst_fixed", {c_NEL{8'd7}}, r_sbq[0].data);
        recv("midrst_grp");

        // Three-beat group with latency and ready-gap checks.
        bias = fill_bias(5); shift = 5'd1; out_ready = 1'b1;
        drive_beat(fill(10), 1'b0);
        drive_beat(fill(10), 1'b0);
        drive_beat(fill(10), 1'b1);
        chk("lat_post_valid", 64'(out_valid),  64'd0);
        chk("lat_post_ready", 64'(psum_ready), 64'd0);
        step();
        chk("lat_out_valid",  64'(out_valid),  64'd1);
        chk("lat_out_ready",  64'(psum_ready), 64'd0);
        ex = r_sbq.pop_front();
        chk_data("lat_data", out_data, ex.data);
        chk("lat_elem0_17", 64'(out_data[7:0]), 64'd17);
        chk("lat_cnt", 64'(beat_cnt), 64'd3);
        step();
        out_ready = 1'b0;
        chk("lat_back_valid", 64'(out_valid),  64'd0);
        chk("lat_back_ready", 64'(psum_ready), 64'd1);

        // ReLU and upper saturation.
        bias = fill_bias(20); shift = 5'd0;
        drive_beat(fill(-100), 1'b1);
        recv("relu");
        bias = fill_bias(0); shift = 5'd2;
        drive_beat(fill(4000), 1'b1);
        recv("sat255");

        // Overflow in one element: saturate or wrap depending on build.
        v = '0;
        v[(5*c_NPIX+2)*c_PW +: c_PW] = 32'h7FFF_FFFF;
        bias = fill_bias(0); shift = 5'd24;
        drive_beat(v, 1'b0);
        drive_beat(v, 1'b1);
        step(); step();
`ifdef ACC_SAT_EN
        chk("ovf_elem", 64'(out_data[(5*c_NPIX+2)*c_OW +: c_OW]), 64'd127);
`else
        chk("ovf_elem", 64'(out_data[(5*c_NPIX+2)*c_OW +: c_OW]), 64'd0);
`endif
        recv("ovf");

        // Randomised mapping group: distinct values per element and per-channel bias.
        for (int c = 0; c < c_CH; c++) bias[c*c_PW +: c_PW] = 32'($urandom_range(1000) - 500);
        shift = 5'($urandom_range(4));
        for (int b = 0; b < 4; b++) begin
            for (int e = 0; e < c_NEL; e++) begin
                val = $urandom_range(4000) - 2000;
                v[e*c_PW +: c_PW] = 32'(val);
            end
            drive_beat(v, b == 3);
        end
        recv("rand");

        // Consumer stall: output held, input beats refused.
        bias = fill_bias(1); shift = 5'd0;
        drive_beat(fill(8), 1'b1);
        step(); step();
        hold = r_sbq[0].data;
        psum_valid = 1'b1; psum = fill(50); psum_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_data("stall_data", out_data, hold);
            chk("stall_ready", 64'(psum_ready), 64'd0);
            step();
        end
        psum_valid = 1'b0;
        recv("stall");
        chk("stall_resume_ready", 64'(psum_ready), 64'd1);
        drive_beat(fill(3), 1'b1);
        recv("after_stall");

        // Beat counter saturation then restart.
        bias = fill_bias(0); shift = 5'd2;
        for (int i = 0; i < 300; i++) drive_beat(fill(1), i == 299);
        recv("long");
        drive_beat(fill(9), 1'b1);
        recv("short");
        chk("short_cnt_fixed", 64'(beat_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
